// File: rtl/sr_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_chain_driver
// Purpose  : Serialises a parallel word LSB-first into a chain of '595-style
//            latched shift registers. It drives SER with a divided SRCLK,
//            pulses RCLK to latch the word, and sequences the chain clear
//            (SRCLR_n) and the output enable (OE_n).
// Options  : SR_DRIVER_AUTOCLEAR_EN - reset arms a pending clear, so the chain
//            is cleared and latched to zero right after reset release.
// Revision : 1.0 - initial release
// ============================================================================
module sr_chain_driver #(
    parameter int WIDTH = 8,
    parameter int CHAIN = 2,
    parameter int DIV   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH*CHAIN-1:0] data,
    input  logic                   valid,
    output logic                   ready,
    input  logic                   clear_req,
    input  logic                   oe,
    output logic                   busy,
    output logic                   SER,
    output logic                   SRCLK,
    output logic                   RCLK,
    output logic                   SRCLR_n,
    output logic                   OE_n
);

    localparam int N  = WIDTH * CHAIN;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = $clog2(2 * DIV + 1);

    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
    localparam logic [DW-1:0] PH_LAST  = DW'(DIV - 1);
    localparam logic [DW-1:0] CLR_LAST = DW'(2 * DIV - 1);

`ifdef SR_DRIVER_AUTOCLEAR_EN
    localparam logic PEND_RST = 1'b1;
`else
    localparam logic PEND_RST = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT_LO = 3'd1,
        S_SHIFT_HI = 3'd2,
        S_LATCH    = 3'd3,
        S_GAP      = 3'd4,
        S_CLEAR    = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [DW-1:0]   phase_cnt, phase_n;
    logic [CW-1:0]   bit_cnt, bit_n;
    logic [N-1:0]    shbuf, shbuf_n;
    logic            pending, pending_n;
    logic            clr_latch, clr_latch_n;
    logic            loaded, loaded_n;
    logic            run;
    logic            ser_q, ser_n;
    logic            srclk_q, srclk_n;
    logic            rclk_q, rclk_n;
    logic            srclr_n_q, srclr_n_n;
    logic            oe_n_q;
    logic            phase_done;
    logic            take_clear;

    // ready needs clear_req combinationally so a same-cycle clear wins over valid
    assign ready      = run && (state == S_IDLE) && !pending && !clear_req;
    assign busy       = (state != S_IDLE);
    assign take_clear = (state == S_IDLE) && (pending || clear_req);
    assign phase_done = (state == S_CLEAR) ? (phase_cnt == CLR_LAST)
                                           : (phase_cnt == PH_LAST);

    assign SER     = ser_q;
    assign SRCLK   = srclk_q;
    assign RCLK    = rclk_q;
    assign SRCLR_n = srclr_n_q;
    assign OE_n    = oe_n_q;

    // Next-state, datapath and pin values; pins are decoded from the next state
    // so the registered outputs line up exactly with the state they belong to
    always_comb begin
        state_n     = state;
        shbuf_n     = shbuf;
        bit_n       = bit_cnt;
        clr_latch_n = clr_latch;
        loaded_n    = loaded;
        pending_n   = pending | clear_req;

        case (state)
            S_IDLE: begin
                if (take_clear) begin
                    state_n   = S_CLEAR;
                    pending_n = 1'b0;
                end else if (valid && ready) begin
                    state_n = S_SHIFT_LO;
                    shbuf_n = data;
                    bit_n   = '0;
                end
            end
            S_SHIFT_LO: begin
                if (phase_done) state_n = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                if (phase_done) begin
                    shbuf_n = shbuf >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = S_LATCH;
                    end else begin
                        state_n = S_SHIFT_LO;
                        bit_n   = bit_cnt + 1'b1;
                    end
                end
            end
            S_LATCH: begin
                if (phase_done) begin
                    state_n     = S_GAP;
                    loaded_n    = 1'b1;
                    clr_latch_n = 1'b0;
                end
            end
            S_GAP: begin
                if (phase_done) state_n = S_IDLE;
            end
            S_CLEAR: begin
                if (phase_done) begin
                    state_n     = S_LATCH;
                    clr_latch_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if ((state_n != state) || (state == S_IDLE)) phase_n = '0;
        else                                          phase_n = phase_cnt + 1'b1;

        ser_n     = ((state_n == S_SHIFT_LO) || (state_n == S_SHIFT_HI)) ? shbuf_n[0] : 1'b0;
        srclk_n   = (state_n == S_SHIFT_HI);
        rclk_n    = (state_n == S_LATCH);
        srclr_n_n = !((state_n == S_CLEAR) || ((state_n == S_LATCH) && clr_latch_n));
    end

    // State, datapath and output registers; reset aborts any transfer at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shbuf     <= '0;
            pending   <= PEND_RST;
            clr_latch <= 1'b0;
            loaded    <= 1'b0;
            run       <= 1'b0;
            ser_q     <= 1'b0;
            srclk_q   <= 1'b0;
            rclk_q    <= 1'b0;
            srclr_n_q <= 1'b1;
            oe_n_q    <= 1'b1;
        end else begin
            state     <= state_n;
            phase_cnt <= phase_n;
            bit_cnt   <= bit_n;
            shbuf     <= shbuf_n;
            pending   <= pending_n;
            clr_latch <= clr_latch_n;
            loaded    <= loaded_n;
            run       <= 1'b1;
            ser_q     <= ser_n;
            srclk_q   <= srclk_n;
            rclk_q    <= rclk_n;
            srclr_n_q <= srclr_n_n;
            oe_n_q    <= ~(oe & loaded);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_chain_driver
// Purpose  : Self-checking bench for sr_chain_driver. Two instances (8x1 at
//            DIV=1, 8x2 at DIV=2) drive behavioural '595 chain models; each
//            latched word is compared against a queue of expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_chain_driver;

`ifdef SR_DRIVER_AUTOCLEAR_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic        clk, rst;
    logic [7:0]  data0;
    logic        valid0, ready0, clr0, oe0, busy0, ser0, srclk0, rclk0, srclr0, oen0;
    logic [15:0] data1;
    logic        valid1, ready1, clr1, oe1, busy1, ser1, srclk1, rclk1, srclr1, oen1;

    int checks   = 0;
    int failures = 0;
    int cycle_cnt = 0;
    int srclk_cnt0 = 0, rclk_cnt0 = 0;
    bit sb_on = 0;

    sr_chain_driver #(.WIDTH(8), .CHAIN(1), .DIV(1)) u0 (
        .clk(clk), .rst(rst), .data(data0), .valid(valid0), .ready(ready0),
        .clear_req(clr0), .oe(oe0), .busy(busy0), .SER(ser0), .SRCLK(srclk0),
        .RCLK(rclk0), .SRCLR_n(srclr0), .OE_n(oen0));

    sr_chain_driver #(.WIDTH(8), .CHAIN(2), .DIV(2)) u1 (
        .clk(clk), .rst(rst), .data(data1), .valid(valid1), .ready(ready1),
        .clear_req(clr1), .oe(oe1), .busy(busy1), .SER(ser1), .SRCLK(srclk1),
        .RCLK(rclk1), .SRCLR_n(srclr1), .OE_n(oen1));

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Chain models: bits enter at the top, so after N shifts bit 0 sits at Q[0]
    // of the far stage; stage 0 (nearest the driver) is the top WIDTH bits.
    logic [7:0]  sh0, q0;
    logic [15:0] sh1, q1;
    always @(posedge srclk0 or negedge srclr0)
        if (!srclr0) sh0 <= '0; else sh0 <= {ser0, sh0[7:1]};
    always @(posedge rclk0) q0 <= sh0;
    always @(posedge srclk1 or negedge srclr1)
        if (!srclr1) sh1 <= '0; else sh1 <= {ser1, sh1[15:1]};
    always @(posedge rclk1) q1 <= sh1;

    always @(posedge srclk0) srclk_cnt0++;
    always @(posedge rclk0)  rclk_cnt0++;
    int rt1[$];
    always @(posedge srclk1) rt1.push_back(cycle_cnt);

    // Scoreboards: compare the chain content at the end of every RCLK pulse
    logic [7:0]  exp0_q[$];
    logic [15:0] exp1_q[$];
    always @(negedge rclk0) if (sb_on) begin
        chk("sb0_expected_latch", exp0_q.size() != 0, 1);
        if (exp0_q.size() != 0) chk("sb0_q", q0, exp0_q.pop_front());
    end
    always @(negedge rclk1) if (sb_on) begin
        chk("sb1_expected_latch", exp1_q.size() != 0, 1);
        if (exp1_q.size() != 0) chk("sb1_q", q1, exp1_q.pop_front());
    end

    // One word or clear on u0; cyc counts the accept cycle as 1
    task automatic op0(input bit clr, input logic [7:0] w, output int cyc, output int oe_fall);
        @(negedge clk);
        chk("u0_ready_before_op", ready0, 1);
        oe_fall = (oen0 === 1'b0) ? -1 : 0;
        if (clr) clr0 = 1'b1;
        else begin data0 = w; valid0 = 1'b1; end
        @(posedge clk); #1;
        clr0 = 1'b0; valid0 = 1'b0; cyc = 1;
        while (ready0 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (oe_fall == 0 && oen0 === 1'b0) oe_fall = cyc;
        end
    endtask

    task automatic op1(input logic [15:0] w, output int cyc, output int t0);
        @(negedge clk);
        chk("u1_ready_before_op", ready1, 1);
        data1 = w; valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0; cyc = 1; t0 = cycle_cnt;
        while (ready1 !== 1'b1 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    endtask

    typedef struct {
        bit         clr;
        logic [7:0] word;
        logic [7:0] exp_q;
        int         exp_cyc;
        int         exp_srclk;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc, oef, t0, rc, sc, n, bad;
        bit acc;
        vecs[0] = '{0, 8'h00, 8'h00, 19, 8};
        vecs[1] = '{0, 8'hFF, 8'hFF, 19, 8};
        vecs[2] = '{0, 8'h01, 8'h01, 19, 8};
        vecs[3] = '{0, 8'h80, 8'h80, 19, 8};
        vecs[4] = '{1, 8'h00, 8'h00,  5, 0};
        vecs[5] = '{0, 8'h3C, 8'h3C, 19, 8};
        vecs[6] = '{0, 8'h96, 8'h96, 19, 8};

        clk = 0; rst = 1;
        valid0 = 0; clr0 = 0; oe0 = 1; data0 = '0;
        valid1 = 0; clr1 = 0; oe1 = 1; data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ser", ser0, 0);
        chk("rst_srclk", srclk0, 0);
        chk("rst_rclk", rclk0, 0);
        chk("rst_srclr_n", srclr0, 1);
        chk("rst_oe_n", oen0, 1);

        @(negedge clk);
        rst = 0; sb_on = 1;
        if (AUTO != 0) begin exp0_q.push_back(8'h00); exp1_q.push_back(16'h0000); end
        #1 chk("ready_release_cycle", ready0, 0);
        @(posedge clk); #1;
        chk("ready_first_clk", ready0, (AUTO != 0) ? 0 : 1);
        cyc = 1;
        while ((ready0 !== 1'b1 || ready1 !== 1'b1) && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("ready_after_release", cyc, (AUTO != 0) ? 9 : 1);

        // First word: 19 cycles, 8 shift pulses, 1 latch, OE_n falls after latch
        exp0_q.push_back(8'hA5);
        sc = srclk_cnt0; rc = rclk_cnt0;
        op0(0, 8'hA5, cyc, oef);
        chk("a5_cycles", cyc, 19);
        chk("a5_srclk_rises", srclk_cnt0 - sc, 8);
        chk("a5_rclk_pulses", rclk_cnt0 - rc, 1);
        chk("a5_q", q0, 8'hA5);
        chk("a5_oe_fall_cycle", oef, (AUTO != 0) ? -1 : 19);

        for (int i = 0; i < 7; i++) begin
            exp0_q.push_back(vecs[i].exp_q);
            sc = srclk_cnt0; rc = rclk_cnt0;
            op0(vecs[i].clr, vecs[i].word, cyc, oef);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("vec%0d_srclk", i), srclk_cnt0 - sc, vecs[i].exp_srclk);
            chk($sformatf("vec%0d_rclk", i), rclk_cnt0 - rc, 1);
            chk($sformatf("vec%0d_q", i), q0, vecs[i].exp_q);
        end

        // OE_n follows oe with one cycle of latency
        @(negedge clk); oe0 = 0;
        @(posedge clk); #1 chk("oe_off", oen0, 1);
        @(negedge clk); oe0 = 1;
        @(posedge clk); #1 chk("oe_on", oen0, 0);

        // Clear and valid in the same IDLE cycle: clear first, word held and taken after
        exp0_q.push_back(8'h00); exp0_q.push_back(8'h3C);
        rc = rclk_cnt0;
        @(negedge clk); data0 = 8'hC3; data0 = 8'h3C; valid0 = 1; clr0 = 1;
        @(posedge clk); #1 clr0 = 0;
        acc = 0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk); n++;
            if (ready0) begin
                chk("clrvalid_q_cleared", q0, 8'h00);
                @(posedge clk); #1 valid0 = 0; acc = 1;
            end
        end
        chk("clrvalid_wait", n, 5);
        n = 0;
        while (ready0 !== 1'b1 && n < 100) begin @(posedge clk); #1 n++; end
        chk("clrvalid_rclk", rclk_cnt0 - rc, 2);
        chk("clrvalid_q", q0, 8'h3C);

        // Clear pulsed mid-transfer; valid while busy is ignored
        exp0_q.push_back(8'hFF); exp0_q.push_back(8'h00);
        rc = rclk_cnt0;
        @(negedge clk); data0 = 8'hFF; valid0 = 1;
        @(posedge clk); #1 valid0 = 0;
        repeat (3) @(negedge clk);
        clr0 = 1;
        @(negedge clk); clr0 = 0; data0 = 8'h77; valid0 = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("busy_ready_low", ready0, 0);
        end
        valid0 = 0;
        n = 0;
        while (ready0 !== 1'b1 && n < 100) begin @(posedge clk); #1 n++; end
        chk("midclr_done", ready0, 1);
        chk("midclr_rclk", rclk_cnt0 - rc, 2);
        chk("midclr_q", q0, 8'h00);

        // Async reset during bit 4 of 0x0F after 0xAA is latched
        exp0_q.push_back(8'hAA);
        op0(0, 8'hAA, cyc, oef);
        chk("pre_rst_q", q0, 8'hAA);
        chk("pre_rst_oe_n", oen0, 0);
        rc = rclk_cnt0; sc = srclk_cnt0;
        @(negedge clk); data0 = 8'h0F; valid0 = 1;
        @(posedge clk); #1 valid0 = 0;
        n = 0;
        while ((srclk_cnt0 - sc) < 5 && n < 50) begin @(posedge clk); #1 n++; end
        chk("rst_mid_srclk_high", srclk0, 1);
        #2 rst = 1;
        #1;
        chk("rst_mid_srclk", srclk0, 0);
        chk("rst_mid_rclk", rclk0, 0);
        chk("rst_mid_oe_n", oen0, 1);
        chk("rst_mid_ser", ser0, 0);
        chk("rst_mid_busy", busy0, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        if (AUTO != 0) begin exp0_q.push_back(8'h00); exp1_q.push_back(16'h0000); end
        n = 0;
        while ((ready0 !== 1'b1 || ready1 !== 1'b1) && n < 50) begin @(posedge clk); #1 n++; end
        chk("rst_mid_rclk_count", rclk_cnt0 - rc, AUTO);
        chk("rst_mid_q_kept", q0, (AUTO != 0) ? 8'h00 : 8'hAA);

        // Two-stage chain at DIV=2
        exp1_q.push_back(16'h12F0);
        rt1.delete();
        op1(16'h12F0, cyc, t0);
        chk("u1_cycles", cyc, 69);
        chk("u1_srclk_rises", rt1.size(), 16);
        if (rt1.size() > 0) chk("u1_first_rise", rt1[0] - t0 + 1, 3);
        bad = 0;
        for (int i = 1; i < rt1.size(); i++) if (rt1[i] - rt1[i-1] != 4) bad++;
        chk("u1_rise_spacing", bad, 0);
        chk("u1_stage0_q", q1[15:8], 8'h12);
        chk("u1_stage1_q", q1[7:0], 8'hF0);

        exp1_q.push_back(16'hA50F);
        op1(16'hA50F, cyc, t0);
        chk("u1_word2_stage0", q1[15:8], 8'hA5);
        chk("u1_word2_stage1", q1[7:0], 8'h0F);

        repeat (4) @(posedge clk);
        chk("sb0_drained", exp0_q.size(), 0);
        chk("sb1_drained", exp1_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
